// File: rtl/i2c_seq.sv
// i2c_seq: table-driven I2C command sequencer.
//
// Walks an external synchronous command table from entry 0 after start_i,
// issuing WRITE/READ commands to an I2C master, inserting programmable delays,
// retrying NACKed transfers up to RETRIES extra times, and stopping at an END
// entry, after the last table entry, or on the first unrecoverable NACK.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   start_i              start pulse, honoured only while idle
//   busy_o, done_o       busy level, one-cycle completion pulse
//   err_o, err_idx_o     sticky abort flag and aborting entry index
//   tbl_addr_o           table index; tbl_data_i valid one cycle later
//   tbl_data_i           {op[1:0], daddr[6:0], addr[7:0], data[7:0]}
//   rd_val_o, rd_data_o  read result pulse and last read byte
//   m_*_o / m_rdy_i      command handshake towards the master
//   m_rsp_*_i / m_rsp_rdy_o  response handshake from the master
module i2c_seq #(
    parameter int DEPTH    = 16,
    parameter int RETRIES  = 3,
    parameter int DLY_UNIT = 1000,
    localparam int IW      = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [IW-1:0] err_idx_o,
    output logic [IW-1:0] tbl_addr_o,
    input  logic [24:0]   tbl_data_i,
    output logic          rd_val_o,
    output logic [7:0]    rd_data_o,
    output logic          m_val_o,
    output logic [6:0]    m_daddr_o,
    output logic [7:0]    m_addr_o,
    output logic [7:0]    m_data_o,
    output logic          m_wen_o,
    input  logic          m_rdy_i,
    input  logic          m_rsp_val_i,
    input  logic          m_rsp_err_i,
    input  logic [7:0]    m_rsp_data_i,
    output logic          m_rsp_rdy_o
);

    localparam int TW = $clog2(RETRIES + 2);
    localparam int PW = $clog2(DLY_UNIT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_RSP, S_DELAY, S_FINISH
    } state_e;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0, OP_READ = 2'd1, OP_DELAY = 2'd2, OP_END = 2'd3
    } op_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [TW-1:0]   tries_q, tries_d;
    logic [15:0]     dcnt_q, dcnt_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic [6:0]      daddr_q, daddr_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      data_q, data_d;
    logic            wen_q, wen_d;
    logic            err_q, err_d;
    logic [IW-1:0]   err_idx_q, err_idx_d;
    logic            rd_val_q, rd_val_d;
    logic [7:0]      rd_data_q, rd_data_d;
    logic            advance;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tries_d   = tries_q;
        dcnt_d    = dcnt_q;
        pre_d     = pre_q;
        daddr_d   = daddr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wen_d     = wen_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        rd_val_d  = 1'b0;
        rd_data_d = rd_data_q;
        advance   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_FETCH;
                    idx_d     = '0;
                    tries_d   = '0;
                    err_d     = 1'b0;
                    err_idx_d = '0;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                daddr_d = tbl_data_i[22:16];
                addr_d  = tbl_data_i[15:8];
                data_d  = tbl_data_i[7:0];
                wen_d   = (op_e'(tbl_data_i[24:23]) == OP_WRITE);
                case (op_e'(tbl_data_i[24:23]))
                    OP_WRITE, OP_READ: state_d = S_ISSUE;
                    OP_DELAY: begin
                        dcnt_d  = tbl_data_i[15:0];
                        pre_d   = '0;
                        state_d = S_DELAY;
                    end
                    default: state_d = S_FINISH;
                endcase
            end
            S_ISSUE: begin
                if (m_rdy_i) state_d = S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                if (m_rsp_val_i) begin
                    if (!m_rsp_err_i) begin
                        if (!wen_q) begin
                            rd_data_d = m_rsp_data_i;
                            rd_val_d  = 1'b1;
                        end
                        advance = 1'b1;
                    end else if (tries_q < TW'(RETRIES)) begin
                        tries_d = tries_q + TW'(1);
                        state_d = S_ISSUE;
                    end else begin
                        err_d     = 1'b1;
                        err_idx_d = idx_q;
                        state_d   = S_FINISH;
                    end
                end
            end
            S_DELAY: begin
                // Leave on the wrap that takes dcnt to zero so N units take
                // exactly N*DLY_UNIT cycles; a zero count leaves at once.
                if (dcnt_q == 16'd0) begin
                    advance = 1'b1;
                end else if (pre_q == PW'(DLY_UNIT - 1)) begin
                    pre_d  = '0;
                    dcnt_d = dcnt_q - 16'd1;
                    if (dcnt_q == 16'd1) advance = 1'b1;
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // The table does not wrap: the last entry always ends the sequence.
        if (advance) begin
            if (idx_q == IW'(DEPTH - 1)) begin
                state_d = S_FINISH;
            end else begin
                idx_d   = idx_q + IW'(1);
                tries_d = '0;
                state_d = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            tries_q   <= '0;
            dcnt_q    <= '0;
            pre_q     <= '0;
            daddr_q   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            wen_q     <= 1'b0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
            rd_val_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tries_q   <= tries_d;
            dcnt_q    <= dcnt_d;
            pre_q     <= pre_d;
            daddr_q   <= daddr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wen_q     <= wen_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
            rd_val_q  <= rd_val_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_FINISH);
    assign err_o       = err_q;
    assign err_idx_o   = err_idx_q;
    assign tbl_addr_o  = idx_q;
    assign rd_val_o    = rd_val_q;
    assign rd_data_o   = rd_data_q;
    assign m_val_o     = (state_q == S_ISSUE);
    assign m_daddr_o   = daddr_q;
    assign m_addr_o    = addr_q;
    assign m_data_o    = data_q;
    assign m_wen_o     = wen_q;
    assign m_rsp_rdy_o = (state_q == S_WAIT_RSP);

endmodule

// File: tb/tb_i2c_seq.sv
// tb_i2c_seq: self-checking bench for i2c_seq.
//
// A synchronous table memory and a cycle-level master model surround the DUT.
// For every scenario a reference walk of the table (computed from the command
// rules, not from the RTL) predicts the command stream, per-command start
// timing, read results, completion timing and error outcome.
module tb_i2c_seq;

    localparam int DEPTH   = 16;
    localparam int RETRIES = 3;
    localparam int U       = 4;
    localparam int IW      = 4;
    localparam int BUDGET  = 3000;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic          busy_o, done_o, err_o;
    logic [IW-1:0] err_idx_o, tbl_addr_o;
    logic [24:0]   tbl_data_i;
    logic          rd_val_o;
    logic [7:0]    rd_data_o;
    logic          m_val_o;
    logic [6:0]    m_daddr_o;
    logic [7:0]    m_addr_o, m_data_o;
    logic          m_wen_o, m_rdy_i;
    logic          m_rsp_val_i, m_rsp_err_i;
    logic [7:0]    m_rsp_data_i;
    logic          m_rsp_rdy_o;

    int testsRun    = 0;
    int testsFailed = 0;

    // Table contents and per-entry master behaviour.
    logic [24:0] tbl   [DEPTH];
    int          nacks [DEPTH];
    logic [7:0]  rdat  [DEPTH];

    // Reference-model predictions.
    logic [23:0] expCmd[$];
    int          expGap[$];
    bit          rspErrQ[$];
    logic [7:0]  rspDatQ[$];
    logic [7:0]  expRd[$];
    int          expDoneGap;
    bit          expErr;
    int          expErrIdx;
    int          expLastIdx;

    always #5 clk = ~clk;

    always @(posedge clk) tbl_data_i <= tbl[tbl_addr_o];

    i2c_seq #(.DEPTH(DEPTH), .RETRIES(RETRIES), .DLY_UNIT(U)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_idx_o(err_idx_o),
        .tbl_addr_o(tbl_addr_o), .tbl_data_i(tbl_data_i),
        .rd_val_o(rd_val_o), .rd_data_o(rd_data_o),
        .m_val_o(m_val_o), .m_daddr_o(m_daddr_o), .m_addr_o(m_addr_o),
        .m_data_o(m_data_o), .m_wen_o(m_wen_o), .m_rdy_i(m_rdy_i),
        .m_rsp_val_i(m_rsp_val_i), .m_rsp_err_i(m_rsp_err_i),
        .m_rsp_data_i(m_rsp_data_i), .m_rsp_rdy_o(m_rsp_rdy_o)
    );

    function automatic logic [24:0] ent(input logic [1:0] op, input logic [6:0] da,
                                        input logic [7:0] a, input logic [7:0] d);
        return {op, da, a, d};
    endfunction

    task automatic clearTable();
        for (int i = 0; i < DEPTH; i++) begin
            tbl[i]   = ent(2'd3, 7'h0, 8'h0, 8'h0);
            nacks[i] = 0;
            rdat[i]  = 8'($urandom);
        end
    endtask

    // Walk the table as the sequencer should. Gaps are measured from the last
    // response accept (or the start cycle): FETCH+DECODE+ISSUE = 3 cycles, a
    // retry reissues 1 cycle after the NACK, each DELAY entry costs FETCH +
    // DECODE + N*U cycles (a zero count still spends its one DELAY cycle).
    task automatic buildModel();
        int idx, d, att, n;
        bit run;
        logic [1:0] op;
        expCmd.delete(); expGap.delete(); rspErrQ.delete(); rspDatQ.delete(); expRd.delete();
        idx = 0; d = 0; run = 1; expErr = 0; expErrIdx = 0; expDoneGap = 0;
        while (run) begin
            op = tbl[idx][24:23];
            if (op == 2'd3) begin
                expDoneGap = d + 3;
                run = 0;
            end else begin
                if (op == 2'd2) begin
                    n = int'(tbl[idx][15:0]);
                    d += 2 + ((n == 0) ? 1 : n * U);
                end else begin
                    att = 0;
                    while (1) begin
                        expCmd.push_back({tbl[idx][22:0], (op == 2'd0)});
                        expGap.push_back((att == 0) ? d + 3 : 1);
                        d = 0;
                        if (att < nacks[idx]) begin
                            rspErrQ.push_back(1'b1);
                            rspDatQ.push_back(8'($urandom));
                            if (att == RETRIES) begin
                                expErr = 1; expErrIdx = idx; expDoneGap = 1; run = 0;
                                break;
                            end
                            att++;
                        end else begin
                            rspErrQ.push_back(1'b0);
                            rspDatQ.push_back(rdat[idx]);
                            if (op == 2'd1) expRd.push_back(rdat[idx]);
                            break;
                        end
                    end
                end
                if (run) begin
                    if (idx == DEPTH - 1) begin
                        expDoneGap = d + 1;
                        run = 0;
                    end else begin
                        idx++;
                    end
                end
            end
        end
        expLastIdx = idx;
    endtask

    // Run one full sequence against the model with the given master latencies.
    // noise: pulse start_i while busy and drive stray responses outside WAIT_RSP.
    task automatic runSeq(input string name, input int rdyLat, input int rspLat, input bit noise);
        int n, refN, hold, waitc, doneCnt, maxIdx, g;
        bit inVal;
        logic [23:0] cap, cur, e;
        logic [7:0] ev;
        buildModel();
        n = 0; refN = 0; hold = 0; waitc = 0; doneCnt = 0; maxIdx = 0; inVal = 0; cap = '0;
        @(negedge clk);
        start_i = 1'b1;
        while (n < BUDGET && doneCnt == 0) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                testsRun++;
                if ({busy_o, err_o, err_idx_o} !== {1'b1, 1'b0, 4'd0}) begin
                    testsFailed++;
                    $display("[TB] FAIL %s start_state: got busy/err/idx %b/%b/%0d required 1/0/0", name, busy_o, err_o, err_idx_o);
                end
            end
            if (int'(tbl_addr_o) > maxIdx) maxIdx = int'(tbl_addr_o);
            if (rd_val_o) begin
                testsRun++;
                if (expRd.size() == 0) begin
                    testsFailed++;
                    $display("[TB] FAIL %s read_extra: got rd_val with %h required no read", name, rd_data_o);
                end else begin
                    ev = expRd.pop_front();
                    if (rd_data_o !== ev || n != refN + 1) begin
                        testsFailed++;
                        $display("[TB] FAIL %s read: got %h at +%0d required %h at +1", name, rd_data_o, n - refN, ev);
                    end
                end
            end
            if (m_val_o) begin
                cur = {m_daddr_o, m_addr_o, m_data_o, m_wen_o};
                if (!inVal) begin
                    inVal = 1; hold = 0; cap = cur;
                    testsRun++;
                    if (expCmd.size() == 0) begin
                        testsFailed++;
                        $display("[TB] FAIL %s cmd_extra: got %h required no command", name, cur);
                    end else begin
                        e = expCmd.pop_front();
                        g = expGap.pop_front();
                        if (cur !== e) begin
                            testsFailed++;
                            $display("[TB] FAIL %s cmd: got %h required %h", name, cur, e);
                        end
                        testsRun++;
                        if (n - refN != g) begin
                            testsFailed++;
                            $display("[TB] FAIL %s cmd_timing: got +%0d cycles required +%0d", name, n - refN, g);
                        end
                    end
                end else begin
                    testsRun++;
                    if (cur !== cap) begin
                        testsFailed++;
                        $display("[TB] FAIL %s cmd_stable: got %h required %h", name, cur, cap);
                    end
                end
                m_rdy_i = (hold >= rdyLat);
                hold++;
            end else begin
                inVal = 0;
                m_rdy_i = 1'b0;
            end
            if (m_rsp_rdy_o) begin
                if (waitc >= rspLat && rspErrQ.size() > 0) begin
                    m_rsp_val_i  = 1'b1;
                    m_rsp_err_i  = rspErrQ.pop_front();
                    m_rsp_data_i = rspDatQ.pop_front();
                    refN = n;
                end else begin
                    m_rsp_val_i = 1'b0;
                    waitc++;
                end
            end else begin
                waitc = 0;
                m_rsp_val_i  = noise ? 1'($urandom) : 1'b0;
                m_rsp_err_i  = 1'b1;
                m_rsp_data_i = 8'($urandom);
            end
            if (done_o) begin
                doneCnt++;
                testsRun++;
                if (n - refN != expDoneGap) begin
                    testsFailed++;
                    $display("[TB] FAIL %s done_timing: got +%0d cycles required +%0d", name, n - refN, expDoneGap);
                end
                testsRun++;
                if ({err_o, err_idx_o} !== {expErr, IW'(expErrIdx)}) begin
                    testsFailed++;
                    $display("[TB] FAIL %s err: got %b/%0d required %b/%0d", name, err_o, err_idx_o, expErr, expErrIdx);
                end
            end
            start_i = noise ? 1'($urandom) : 1'b0;
        end
        start_i = 1'b0; m_rdy_i = 1'b0; m_rsp_val_i = 1'b0; m_rsp_err_i = 1'b0;
        testsRun++;
        if (doneCnt != 1) begin
            testsFailed++;
            $display("[TB] FAIL %s done_seen: got %0d pulses required 1 within %0d cycles", name, doneCnt, BUDGET);
        end
        testsRun++;
        if (expCmd.size() != 0 || expRd.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL %s leftovers: got %0d cmds %0d reads pending required 0", name, expCmd.size(), expRd.size());
        end
        testsRun++;
        if (maxIdx != expLastIdx) begin
            testsFailed++;
            $display("[TB] FAIL %s last_fetch: got %0d required %0d", name, maxIdx, expLastIdx);
        end
        repeat (3) begin
            @(negedge clk);
            testsRun++;
            if ({busy_o, done_o, err_o} !== {1'b0, 1'b0, expErr}) begin
                testsFailed++;
                $display("[TB] FAIL %s idle_after: got busy/done/err %b/%b/%b required 0/0/%b", name, busy_o, done_o, err_o, expErr);
            end
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; start_i = 1'b0; m_rdy_i = 1'b0;
        m_rsp_val_i = 1'b0; m_rsp_err_i = 1'b0; m_rsp_data_i = 8'h0;
        clearTable();
        repeat (2) @(negedge clk);
        testsRun++;
        if ({busy_o, done_o, err_o, err_idx_o, tbl_addr_o, rd_val_o, rd_data_o, m_val_o,
             m_daddr_o, m_addr_o, m_data_o, m_wen_o, m_rsp_rdy_o} !== 46'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got busy %b done %b m_val %b m_wen %b rsp_rdy %b required all 0",
                     busy_o, done_o, m_val_o, m_wen_o, m_rsp_rdy_o);
        end
        rst_ni = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        clearTable();
        tbl[0] = ent(2'd0, 7'h50, 8'h10, 8'hA5);
        runSeq("write", 0, 0, 0);
    endtask

    task automatic test_read();
        clearTable();
        tbl[0] = ent(2'd1, 7'h68, 8'h75, 8'h00);
        rdat[0] = 8'h71;
        runSeq("read", 0, 0, 0);
    endtask

    task automatic test_retry();
        clearTable();
        for (int i = 0; i < 4; i++) tbl[i] = ent(2'(i & 1), 7'($urandom), 8'($urandom), 8'($urandom));
        nacks[2] = 3;
        runSeq("retry", 0, 1, 0);
    endtask

    task automatic test_abort();
        clearTable();
        for (int i = 0; i < 4; i++) tbl[i] = ent(2'd0, 7'($urandom), 8'($urandom), 8'($urandom));
        nacks[1] = 99;
        runSeq("abort", 1, 0, 0);
    endtask

    task automatic test_delay();
        clearTable();
        tbl[0] = ent(2'd0, 7'h50, 8'h01, 8'h11);
        tbl[1] = ent(2'd2, 7'h00, 8'h00, 8'h03);
        tbl[2] = ent(2'd1, 7'h50, 8'h02, 8'h00);
        runSeq("delay3", 0, 0, 0);
        clearTable();
        tbl[0] = ent(2'd0, 7'h51, 8'h01, 8'h22);
        tbl[1] = ent(2'd2, 7'h00, 8'h00, 8'h00);
        tbl[2] = ent(2'd0, 7'h51, 8'h02, 8'h33);
        runSeq("delay0", 0, 0, 0);
    endtask

    task automatic test_full_table();
        clearTable();
        for (int i = 0; i < DEPTH; i++) tbl[i] = ent(2'd0, 7'($urandom), 8'($urandom), 8'($urandom));
        runSeq("full_table", 0, 0, 0);
    endtask

    task automatic test_stall();
        clearTable();
        tbl[0] = ent(2'd0, 7'h3C, 8'h20, 8'h5A);
        tbl[1] = ent(2'd1, 7'h3C, 8'h21, 8'h00);
        runSeq("stall", 50, 2, 0);
    endtask

    task automatic test_busy_start();
        clearTable();
        for (int i = 0; i < 6; i++) tbl[i] = ent(2'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom));
        nacks[3] = 2;
        runSeq("busy_start", 2, 2, 1);
    endtask

    task automatic test_random();
        int r;
        for (int it = 0; it < 8; it++) begin
            clearTable();
            for (int i = 0; i < DEPTH; i++) begin
                r = $urandom_range(0, 19);
                if (r < 10)      tbl[i] = ent(2'd0, 7'($urandom), 8'($urandom), 8'($urandom));
                else if (r < 16) tbl[i] = ent(2'd1, 7'($urandom), 8'($urandom), 8'($urandom));
                else if (r < 19) tbl[i] = ent(2'd2, 7'($urandom), 8'h00, 8'($urandom_range(1, 3)));
                else             tbl[i] = ent(2'd3, 7'h0, 8'h0, 8'h0);
                r = $urandom_range(0, 19);
                nacks[i] = (r < 14) ? 0 : (r < 19) ? $urandom_range(1, 3) : 4;
            end
            runSeq("random", $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        clearTable();
        tbl[0] = ent(2'd1, 7'h22, 8'h33, 8'h00);
        found = 0;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (m_rsp_rdy_o) found = 1;
            else m_rdy_i = m_val_o;
        end
        m_rdy_i = 1'b0;
        testsRun++;
        if (!found) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_reach: got no WAIT_RSP required it within 20 cycles");
        end
        rst_ni = 1'b0;
        #1;
        testsRun++;
        if ({busy_o, done_o, err_o, err_idx_o, tbl_addr_o, rd_val_o, rd_data_o, m_val_o,
             m_daddr_o, m_addr_o, m_data_o, m_wen_o, m_rsp_rdy_o} !== 46'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid_outputs: got busy %b rsp_rdy %b daddr %h rd_data %h required all 0",
                     busy_o, m_rsp_rdy_o, m_daddr_o, rd_data_o);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (4) begin
            @(negedge clk);
            testsRun++;
            if ({busy_o, done_o} !== 2'b00) begin
                testsFailed++;
                $display("[TB] FAIL reset_mid_idle: got busy/done %b/%b required 0/0", busy_o, done_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_retry();
        test_abort();
        test_delay();
        test_full_table();
        test_stall();
        test_busy_start();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/i2c_seq.md
# i2c_seq

Table-driven I2C command sequencer that sits directly upstream of the I2C master, driving its command handshake (device address, register address, data, write-enable) and consuming its response handshake (done/error/read data). On `start_i` it walks an external synchronous command table from entry 0, issuing register writes and reads, inserting programmable delays, retrying NACKed transfers, and stopping at an END entry, the last entry, or the first unrecoverable error. It is used for power-up configuration of on-board I2C peripherals and for scripted register readback.

## Interface
- `DEPTH`, 16: number of table entries; index width `IW = $clog2(DEPTH)`.
- `RETRIES`, 3: extra attempts after a NACK before aborting; 0 = no retry.
- `DLY_UNIT`, 1000: clock cycles per delay unit.

- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  start pulse; sampled only in IDLE.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle pulse at end of sequence (success or abort).
- `err_o`  out  1  sticky abort flag; cleared on accepted `start_i`.
- `err_idx_o`  out  IW  index of the aborting entry; cleared on accepted `start_i`.
- `tbl_addr_o`  out  IW  table index; `tbl_data_i` valid one cycle later.
- `tbl_data_i`  in  25  entry `{op[1:0], daddr[6:0], addr[7:0], data[7:0]}`; op 0 = WRITE, 1 = READ, 2 = DELAY, 3 = END.
- `rd_val_o`  out  1  one-cycle pulse with read result.
- `rd_data_o`  out  8  last read byte; holds its value between reads.
- `m_val_o`  out  1  command valid to the master.
- `m_daddr_o`  out  7  device address.
- `m_addr_o`  out  8  register address.
- `m_data_o`  out  8  write data.
- `m_wen_o`  out  1  1 = write, 0 = read.
- `m_rdy_i`  in  1  master accepts command.
- `m_rsp_val_i`  in  1  master response valid.
- `m_rsp_err_i`  in  1  NACK seen.
- `m_rsp_data_i`  in  8  read data.
- `m_rsp_rdy_o`  out  1  response accept.

## Operation
- States: IDLE, FETCH, DECODE, ISSUE, WAIT_RSP, DELAY, FINISH.
- IDLE → FETCH on `start_i`. On that edge: `idx` = 0, `tries` = 0, `err_o` = 0, `err_idx_o` = 0.
- FETCH: `tbl_addr_o` = `idx` (registered). Always → DECODE.
- DECODE: register `tbl_data_i` fields into the command registers. Next state by op:
  - WRITE / READ → ISSUE.
  - DELAY → DELAY, loading `dcnt` = `{addr,data}` (16-bit unit count) and prescaler = 0.
  - END → FINISH.
- ISSUE: `m_val_o` = 1. `m_*_o` stay constant while valid. `m_wen_o` = 1 for WRITE, 0 for READ. On `m_val_o & m_rdy_i` → WAIT_RSP.
- WAIT_RSP: `m_rsp_rdy_o` = 1 (combinational, this state only). On `m_rsp_val_i`:
  - err = 0: for READ, latch `rd_data_o` and pulse `rd_val_o` next cycle. Then advance.
  - err = 1, `tries < RETRIES`: `tries++`, → ISSUE with the same command.
  - err = 1, `tries == RETRIES`: `err_o` = 1, `err_idx_o` = `idx`, → FINISH.
- DELAY: prescaler counts `0..DLY_UNIT-1`; each wrap decrements `dcnt`. `dcnt` = 0 (including 0 loaded at DECODE) → advance.
- Advance: if `idx == DEPTH-1` → FINISH (no wrap). Otherwise `idx++`, `tries` = 0, → FETCH.
- FINISH: `done_o` = 1 for one cycle, → IDLE.
- `start_i` outside IDLE is ignored. `m_rsp_val_i` outside WAIT_RSP is ignored (not acknowledged).
- Reset values: every output 0, state IDLE, `idx` / `tries` / `dcnt` = 0. Reset mid-sequence aborts immediately, with no `done_o`.

## Timing
- `start_i` sampled at edge 0 → FETCH during cycle 1 → DECODE cycle 2 → `m_val_o` high in cycle 3 for the first WRITE/READ.
- Back-to-back entries: 3 cycles from response accept to the next `m_val_o` (FETCH, DECODE, ISSUE). Retry: `m_val_o` reasserted the cycle after the NACK response.
- DELAY of N units: exactly N×DLY_UNIT cycles in DELAY, then FETCH.
- END at index k: `done_o` asserted 2 cycles after FETCH of k.
- `rd_val_o` and the `rd_data_o` update land in the same cycle, one cycle after response accept.

## Test plan
- Table [WRITE 0x50/0x10/0xA5, END]; master ready immediately, responds OK → one command `{0x50,0x10,0xA5,wen=1}`, first `m_val_o` at cycle 3, `done_o` once, `err_o` = 0.
- Table [READ 0x68/0x75, END]; response data 0x71 → `m_wen_o` = 0, `rd_val_o` pulse with `rd_data_o` = 0x71.
- Entry 2 NACKs 3 times, then ACK (RETRIES = 3) → 4 identical commands, sequence continues, `err_o` = 0.
- Entry 1 always NACKs → 4 attempts, `err_o` = 1, `err_idx_o` = 1, `done_o` pulse, entry 2 never fetched.
- DELAY `{0x00,0x03}` with DLY_UNIT = 4 → 12 cycles in DELAY. DELAY 0 → no wait. Full 16 WRITE entries with no END → stops after index 15 without wrap.
- `start_i` while busy is ignored. `m_rdy_i` held low for 50 cycles → `m_*_o` stable throughout. `rst_ni` low in WAIT_RSP → all outputs 0, IDLE.
